// File: rtl/port_input_conditioner.sv
// Synchronises and debounces the DE1-SoC switches and keys for the port interlock; stable after 2+DB_CYCLES edges.
// Outputs are combinational on debounced state only, with press pulses and mutual exclusion on contradictory pairs.
module port_input_conditioner #(
  parameter int DB_CYCLES = 200,
  parameter int CNT_W     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] key_n,
  input  logic [4:0] sw,
  output logic       arrive,
  output logic       depart,
  output logic       iport,
  output logic       oport,
  output logic       select,
  output logic [2:0] key_level,
  output logic [2:0] key_pulse,
  output logic       port_conflict,
  output logic       motion_conflict
);

  localparam int LANES = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Lanes 2:0 are keys (inverted to active-high), lanes 7:3 are SW[4:0].
  logic [LANES-1:0] raw;
  logic [LANES-1:0] s1;
  logic [LANES-1:0] s2;
  logic [LANES-1:0] stable;
  logic [2:0]       prev;
  logic [CNT_W-1:0] cnt [LANES];

  assign raw = {sw, ~key_n};

  always_ff @(posedge clock) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      prev   <= '0;
      for (int i = 0; i < LANES; i++) cnt[i] <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      prev <= stable[2:0];
      for (int i = 0; i < LANES; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  logic       fill_s;
  logic       drain_s;
  logic [2:0] press;

  assign fill_s  = stable[0];
  assign drain_s = stable[1];
  assign press   = stable[2:0] & ~prev;

  // A press is dropped while the opposing key is held; releasing it later never revives the pulse.
  assign key_level = {stable[2], drain_s & ~fill_s, fill_s & ~drain_s};
  assign key_pulse = {press[2], press[1] & ~fill_s, press[0] & ~drain_s};

  assign arrive          = stable[3] & ~stable[4];
  assign depart          = stable[4] & ~stable[3];
  assign motion_conflict = stable[3] & stable[4];
  assign oport           = stable[5] & ~stable[6];
  assign iport           = stable[6] & ~stable[5];
  assign port_conflict   = stable[5] & stable[6];
  assign select          = stable[7];

endmodule

// File: tb/tb_port_input_conditioner.sv
// Bench for port_input_conditioner at DB_CYCLES=4: per-cycle scoreboard against a window-based
// debounce model, plus targeted timing checks for each scenario.
module tb_port_input_conditioner;

  localparam int DB = 4;

  logic       clock;
  logic       reset;
  logic [2:0] key_n;
  logic [4:0] sw;
  logic       arrive, depart, iport, oport, select;
  logic [2:0] key_level, key_pulse;
  logic       port_conflict, motion_conflict;

  port_input_conditioner #(.DB_CYCLES(DB), .CNT_W(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .key_n          (key_n),
    .sw             (sw),
    .arrive         (arrive),
    .depart         (depart),
    .iport          (iport),
    .oport          (oport),
    .select         (select),
    .key_level      (key_level),
    .key_pulse      (key_pulse),
    .port_conflict  (port_conflict),
    .motion_conflict(motion_conflict)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;

  // Output vector: [12]arrive [11]depart [10]iport [9]oport [8]select
  // [7:5]key_level [4:2]key_pulse [1]port_conflict [0]motion_conflict
  logic [12:0] exp_q [$];
  logic [12:0] obs;

  logic [7:0]    m_s1, m_s2, m_stable;
  logic [2:0]    m_prev;
  logic [DB-1:0] m_hist [8];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [12:0] model_outs();
    logic       f, d, arr, dep, op, ip;
    logic [2:0] press, lvl, pul;
    f     = m_stable[0];
    d     = m_stable[1];
    arr   = m_stable[3];
    dep   = m_stable[4];
    op    = m_stable[5];
    ip    = m_stable[6];
    press = m_stable[2:0] & ~m_prev;
    lvl   = {m_stable[2], d & ~f, f & ~d};
    pul   = {press[2], press[1] & ~f, press[0] & ~d};
    return {arr & ~dep, dep & ~arr, ip & ~op, op & ~ip, m_stable[7], lvl, pul, ip & op, arr & dep};
  endfunction

  function automatic logic [12:0] dut_outs();
    return {arrive, depart, iport, oport, select, key_level, key_pulse, port_conflict, motion_conflict};
  endfunction

  // Stable flips once the last DB synchronised samples all disagree with it.
  task automatic model_edge(input logic [2:0] k, input logic [4:0] s, input logic r);
    logic [7:0] nxt;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0;
      for (int i = 0; i < 8; i++) m_hist[i] = '0;
    end else begin
      nxt = m_stable;
      for (int i = 0; i < 8; i++) begin
        m_hist[i] = {m_hist[i][DB-2:0], m_s2[i]};
        if (m_hist[i] == {DB{~m_stable[i]}}) nxt[i] = ~m_stable[i];
      end
      m_prev   = m_stable[2:0];
      m_stable = nxt;
      m_s2     = m_s1;
      m_s1     = {s, ~k};
    end
    exp_q.push_back(model_outs());
  endtask

  task automatic step(input logic [2:0] k, input logic [4:0] s, input logic r);
    logic [12:0] e;
    key_n = k;
    sw    = s;
    reset = r;
    model_edge(k, s, r);
    @(posedge clock);
    @(negedge clock);
    obs = dut_outs();
    check_eq("sb_depth", 32'(exp_q.size()), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("outs", 32'(obs), 32'(e));
    end
  endtask

  task automatic idle_reset();
    step(3'b111, 5'h00, 1'b1);
    step(3'b111, 5'h00, 1'b1);
    check_eq("idle_rst_outs", 32'(obs), 0);
    step(3'b111, 5'h00, 1'b0);
    step(3'b111, 5'h00, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, p1, lvl0_cnt;
    reset = 1'b1;
    key_n = 3'b111;
    sw    = 5'h00;
    @(negedge clock);

    // Reset with everything active, then release.
    step(3'b000, 5'h1F, 1'b1);
    check_eq("s1_rst_a", 32'(obs), 0);
    step(3'b000, 5'h1F, 1'b1);
    check_eq("s1_rst_b", 32'(obs), 0);
    for (int n = 1; n <= 10; n++) begin
      step(3'b000, 5'h1F, 1'b0);
      if (n == 5) begin
        check_eq("s1_sel_early", 32'(obs[8]), 0);
        check_eq("s1_lvl2_early", 32'(obs[7]), 0);
      end
      if (n == 6) begin
        check_eq("s1_sel_rise", 32'(obs[8]), 1);
        check_eq("s1_lvl2_rise", 32'(obs[7]), 1);
        check_eq("s1_pulse2", 32'(obs[4]), 1);
        check_eq("s1_fill_drain_excl", 32'(obs[6:5]), 0);
        check_eq("s1_pair_outs_zero", 32'(obs[12:9]), 0);
        check_eq("s1_conflicts", 32'(obs[1:0]), 3);
      end
      if (n == 7) check_eq("s1_pulse2_once", 32'(obs[4]), 0);
    end
    idle_reset();

    // SW[0] bounce then hold high.
    for (int n = 1; n <= 12; n++) begin
      step(3'b111, {4'b0, (n > 4) ? 1'b1 : ((n % 2) == 1)}, 1'b0);
      if (n <= 9) check_eq("s2_no_early_arrive", 32'(obs[12]), 0);
      if (n == 10) check_eq("s2_arrive_rise", 32'(obs[12]), 1);
    end
    idle_reset();

    // Clean fill press and release.
    p0 = 0;
    lvl0_cnt = 0;
    for (int n = 1; n <= 34; n++) begin
      step((n <= 20) ? 3'b110 : 3'b111, 5'h00, 1'b0);
      p0 += int'(obs[2]);
      lvl0_cnt += int'(obs[5]);
      if (n == 6) check_eq("s3_pulse_at_rise", 32'(obs[2]), 1);
      if (n == 25) check_eq("s3_lvl_held", 32'(obs[5]), 1);
      if (n == 26) check_eq("s3_release", 32'(obs[5]), 0);
    end
    check_eq("s3_pulse_count", p0, 1);
    check_eq("s3_level_cycles", lvl0_cnt, 20);
    idle_reset();

    // Fill held, drain pressed 10 edges later.
    p0 = 0;
    p1 = 0;
    for (int n = 1; n <= 56; n++) begin
      step({1'b1, ~(n >= 11 && n <= 45), ~(n <= 30)}, 5'h00, 1'b0);
      p0 += int'(obs[2]);
      p1 += int'(obs[3]);
      if (n == 15) check_eq("s4_fill_only", 32'(obs[6:5]), 1);
      if (n == 16) check_eq("s4_both_masked", 32'(obs[6:5]), 0);
      if (n == 35) check_eq("s4_still_masked", 32'(obs[6:5]), 0);
      if (n == 36) check_eq("s4_drain_reasserts", 32'(obs[6:5]), 2);
      if (n == 51) check_eq("s4_drain_released", 32'(obs[6:5]), 0);
    end
    check_eq("s4_fill_pulses", p0, 1);
    check_eq("s4_drain_pulses", p1, 0);
    idle_reset();

    // iport/oport conflict then clear iport.
    for (int n = 1; n <= 20; n++) begin
      step(3'b111, (n <= 10) ? 5'b01100 : 5'b00100, 1'b0);
      if (n == 5) check_eq("s5_pre_conflict", 32'(obs[1]), 0);
      if (n == 6) begin
        check_eq("s5_conflict", 32'(obs[1]), 1);
        check_eq("s5_ports_masked", 32'(obs[10:9]), 0);
      end
      if (n == 15) check_eq("s5_conflict_held", 32'(obs[1]), 1);
      if (n == 16) begin
        check_eq("s5_conflict_clear", 32'(obs[1]), 0);
        check_eq("s5_oport_only", 32'(obs[10:9]), 1);
      end
    end
    idle_reset();

    // Reset in the middle of depart debouncing.
    for (int n = 1; n <= 14; n++) begin
      step(3'b111, 5'b00010, n == 4);
      if (n == 4) check_eq("s6_in_reset", 32'(obs), 0);
      if (n == 9) check_eq("s6_depart_early", 32'(obs[11]), 0);
      if (n == 10) check_eq("s6_depart_rise", 32'(obs[11]), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
